// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the gray ticket arbiter.
// Provides the FSM state enum, default sizes and the bin2gray helper.
package gray_arb_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    // Callers truncate the result to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_counter.sv
// Binary step counter presenting its value in gray code.
// Ports: clk, reset (sync, active-high), inc (advance by one), gray (code out).
module gray_step_counter
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] bin;

    // Natural binary wrap gives the gray wrap (top code back to zero).
    always_ff @(posedge clk) begin
        if (reset) begin
            bin <= '0;
        end else if (inc) begin
            bin <= bin + WIDTH'(1);
        end
    end

    assign gray = WIDTH'(bin2gray(32'(bin)));

endmodule

// File: rtl/gray_ticket_arbiter.sv
// Round-robin arbiter that hands each winner the current gray ticket.
// Ports: clk, reset (sync, active-high), enable, req, done in;
//   gnt (one-cycle one-hot), gnt_id, ticket, busy out.
// Optional macro GRAY_TIMEOUT_EN adds TIMEOUT_CYCLES forced release
//   and the sticky timeout_err output.
module gray_ticket_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
`ifdef GRAY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic [WIDTH-1:0]           ticket,
    output logic                       busy
`ifdef GRAY_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int IW  = IDW + 1;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr;
    logic [IDW-1:0]   winner;
    logic [IW-1:0]    idx;
    logic             found;
    logic             fire;
    logic [WIDTH-1:0] gray;

`ifdef GRAY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          tmo;
`endif

    gray_step_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fire),
        .gray  (gray)
    );

    // Scan from the rr pointer, wrapping, and keep the first hit.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr} + IW'(i);
            if (idx >= IW'(NUM_REQ)) begin
                idx = idx - IW'(NUM_REQ);
            end
            if (!found && req[idx[IDW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fire       = 1'b0;
`ifdef GRAY_TIMEOUT_EN
        tmo        = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (enable && found) begin
                    fire       = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                state_next = done ? IDLE : BUSY;
            end
            BUSY: begin
                if (done) begin
                    state_next = IDLE;
                end
`ifdef GRAY_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // gnt is a pulse; id and ticket hold until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= '0;
            gnt_id <= '0;
            ticket <= '0;
            rr     <= '0;
        end else begin
            gnt <= '0;
            if (fire) begin
                gnt    <= NUM_REQ'(1) << winner;
                gnt_id <= winner;
                ticket <= gray;
                rr     <= (winner == IDW'(NUM_REQ - 1)) ?
                          '0 : winner + IDW'(1);
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef GRAY_TIMEOUT_EN
    // Held at zero outside BUSY, so it restarts on every BUSY entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != BUSY) begin
                tcnt <= '0;
            end else if (!done) begin
                tcnt <= tcnt + TW'(1);
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/gray_ticket_arbiter.md
Name: gray_ticket_arbiter

Overview:
- Shares one gray-code sequence counter among NUM_REQ requesters.
- Round-robin arbitration. Each grant hands the winner the current gray ticket, then advances the counter by one gray step.
- The granted requester owns the resource until it pulses done.
- Sits in front of the gray counter datapath as its scheduler. It is the only agent that advances the count.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, gray ticket width in bits.
- TIMEOUT_CYCLES, 16, max BUSY cycles before forced release. Used only with GRAY_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high permits new grants and counter advance.
- req  input  NUM_REQ  per-requester request level. Held until granted.
- done  input  1  one-cycle pulse from current owner releasing the resource.
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
- gnt_id  output  $clog2(NUM_REQ)  index of current/last owner.
- ticket  output  WIDTH  gray code value issued with the grant. Stable until the next grant.
- busy  output  1  high while the resource is owned (GRANT or BUSY state).
- timeout_err  output  1  sticky forced-release flag. Present only with GRAY_TIMEOUT_EN.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - gnt=0, gnt_id=0, ticket=0, busy=0, timeout_err=0.
  - Internal binary count=0, rr pointer=0, state=IDLE.
- Reset mid-operation: abandons any ownership on the next edge. No grant is issued in that cycle.
- Counter:
  - Internal binary count bin[WIDTH-1:0]; gray = bin ^ (bin>>1).
  - Advances by 1 exactly in the cycle a grant is issued.
  - Wraps 2^WIDTH-1 → 0. For WIDTH=4, gray goes 1000 → 0000.
- FSM states: IDLE, GRANT, BUSY.
- IDLE:
  - If enable=1 and |req, pick the winner: the first set req at or after rr pointer, wrapping.
  - Next cycle: state=GRANT, gnt=onehot(winner), gnt_id=winner, ticket=gray(current bin), bin+=1, rr pointer=winner+1 mod NUM_REQ, busy=1.
  - If enable=0 or req=0: stay in IDLE, no counter change.
- GRANT: lasts exactly one cycle.
  - gnt drops to 0 and the FSM goes to BUSY.
  - If done is high in GRANT, go to IDLE instead.
- BUSY:
  - Hold until done=1, then go to IDLE with busy=0 on the next edge.
  - done is honoured regardless of enable.
- Latency:
  - req sampled in IDLE cycle N → gnt high in cycle N+1.
  - done in cycle M → IDLE in M+1 → earliest next gnt in M+2. One bubble is required.
- done while in IDLE is ignored.
- req changing while BUSY has no effect until IDLE.
- enable=0 during BUSY: ownership continues. Only new grants are blocked.
- Every grant asserts exactly one gnt bit. Two consecutive tickets always differ in exactly one bit.

Optional Feature:
- Macro: GRAY_TIMEOUT_EN.
- Defined:
  - A BUSY cycle counter runs while in BUSY.
  - On reaching TIMEOUT_CYCLES without done, the FSM forces IDLE.
  - timeout_err is set and stays at 1 until reset.
  - The counter clears on entering BUSY.
- Undefined:
  - No timeout counter and no timeout_err port.
  - BUSY waits for done indefinitely.

Decomposition:
- Package gray_arb_pkg:
  - State enum: IDLE=2'd0, GRANT=2'd1, BUSY=2'd2.
  - Function bin2gray.
  - Default WIDTH and NUM_REQ constants.
- Sub-module gray_step_counter:
  - WIDTH-bit binary register with increment-enable and synchronous reset.
  - Outputs the gray value.
- Arbiter logic and FSM live in the top level.

Test Plan:
- Reset held for 2 cycles with req=4'b1111 → gnt=0, ticket=0000, busy=0. After release with enable=1, the first gnt is 4'b0001 with ticket=0000.
- req=4'b1111 held, done pulsed in each BUSY cycle → grant order 0,1,2,3,0. Tickets are 0000, 0001, 0011, 0010, 0110.
- 16 grants from req=4'b0100 only:
  - Tickets follow the full 4-bit gray cycle, and the 16th is 1000.
  - The 17th grant carries ticket 0000 (wrap).
  - Every grant has gnt_id=2.
- enable=0 with req=4'b0010 in IDLE for 5 cycles → no gnt and the counter is unchanged. enable=1 → gnt=4'b0010 on the next cycle.
- Reset asserted during BUSY → busy=0 and state IDLE on the next edge. The next grant ticket is 0000 and rr pointer restarts at 0.
- With GRAY_TIMEOUT_EN and TIMEOUT_CYCLES=16, grant with no done → forced IDLE after 16 BUSY cycles and timeout_err=1. It stays at 1 through further grants until reset.
